// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch FSM (REQ/WAIT/OUT/FAULT).
// Optional macro FETCH_WRAP_TRAP_EN: trap instead of wrapping past 32'hFFFF_FFFC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic        flush;
    logic        br_ok;
    logic        br_bad;
    logic        wrap_trap;

    assign br_ok  = branch_taken && (branch_target[1:0] == 2'b00);
    assign br_bad = branch_taken && (branch_target[1:0] != 2'b00);

`ifdef FETCH_WRAP_TRAP_EN
    assign wrap_trap = (pc == 32'hFFFF_FFFC);
`else
    assign wrap_trap = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a misaligned branch wins over everything else.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_REQ: begin
                if (br_bad) begin
                    state_nx = S_FAULT;
                end else if (imem_req_ready) begin
                    // A branch on the accept edge still leaves one response
                    // in flight; WAIT drains it under the flush flag.
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (br_bad) begin
                    state_nx = S_FAULT;
                end else if (imem_rsp_valid) begin
                    if (flush || br_ok) begin
                        state_nx = S_REQ;
                    end else if (wrap_trap) begin
                        state_nx = S_FAULT;
                    end else begin
                        state_nx = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (br_bad) begin
                    state_nx = S_FAULT;
                end else if (br_ok || !stall) begin
                    state_nx = S_REQ;
                end
            end
            S_FAULT: begin
                state_nx = S_FAULT;
            end
            default: begin
                state_nx = S_FAULT;
            end
        endcase
    end

    // PC, flush flag, presented instruction and fault address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            flush    <= 1'b0;
            instr    <= 32'h0;
            instr_pc <= 32'h0;
            fault_pc <= 32'h0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (br_bad) begin
                        fault_pc <= branch_target;
                    end else if (br_ok) begin
                        pc <= branch_target;
                        if (imem_req_ready) begin
                            flush <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (br_bad) begin
                        fault_pc <= branch_target;
                        flush    <= 1'b0;
                    end else if (imem_rsp_valid) begin
                        flush <= 1'b0;
                        if (br_ok) begin
                            pc <= branch_target;
                        end else if (!flush) begin
                            if (wrap_trap) begin
                                fault_pc <= pc;
                            end else begin
                                instr    <= imem_rsp_data;
                                instr_pc <= pc;
                                pc       <= pc + 32'd4;
                            end
                        end
                    end else if (br_ok) begin
                        pc    <= branch_target;
                        flush <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (br_bad) begin
                        fault_pc <= branch_target;
                    end else if (br_ok) begin
                        pc <= branch_target;
                    end
                end
                S_FAULT: begin
                    pc <= pc;
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    // Outputs decoded from state; no request while reset is held.
    always_comb begin
        imem_req_valid = (state == S_REQ) && !reset;
        imem_addr      = pc;
        instr_valid    = (state == S_OUT);
        fault          = (state == S_FAULT);
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  consumer not ready; holds the presented instruction.
- branch_taken  in  1  redirect request, sampled on the clock edge.
- branch_target  in  32  redirect address.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  fetch address.
- imem_rsp_valid  in  1  response valid, one-cycle pulse.
- imem_rsp_data  in  32  fetched word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr  out  32  instruction word.
- instr_pc  out  32  address of instr.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  address that caused the fault.

Function
REQ-003 The block SHALL implement the FSM states REQ, WAIT, OUT and FAULT.
REQ-004 In REQ, the block SHALL drive imem_req_valid=1 and imem_addr=pc, and SHALL move to WAIT on the edge where imem_req_ready=1.
REQ-005 imem_addr SHALL remain stable while imem_req_valid=1 and imem_req_ready=0.
REQ-006 At most one request SHALL be outstanding, and imem_req_valid SHALL be 0 in WAIT, OUT and FAULT.
REQ-007 In WAIT, on imem_rsp_valid, the block SHALL register instr<=imem_rsp_data, instr_pc<=pc and pc<=pc+4, then enter OUT.
REQ-008 The PC increment SHALL be a 32-bit unsigned add, with the carry out of bit 31 not stored.
REQ-009 In OUT, instr_valid SHALL be 1; if stall=0 the block SHALL enter REQ next cycle, and if stall=1 it SHALL stay in OUT with instr and instr_pc held.
REQ-010 Latency SHALL be: accepted request to instr_valid = response latency + 1 cycle, so a zero-wait memory gives 3 cycles per instruction.
REQ-011 On branch_taken in REQ or OUT, the block SHALL set pc<=branch_target, drop instr_valid on the next cycle and enter REQ, with branch taking priority over stall.
REQ-012 On branch_taken in WAIT, the block SHALL set pc<=branch_target and set a flush flag.
REQ-013 When a response arrives with the flush flag set, the block SHALL discard it, clear the flag and enter REQ with no instr_valid; this also applies when the branch and the response fall on the same edge.
REQ-014 A branch_taken with branch_target[1:0]!=0 SHALL move the block to FAULT with fault_pc=branch_target; any outstanding response SHALL be ignored.
REQ-015 In FAULT, the block SHALL hold fault=1 and instr_valid=0 and issue no requests until reset; branch_taken SHALL be ignored.
REQ-016 When branch_taken=0, a branch_target value SHALL have no effect.

Reset
REQ-017 On reset assertion, regardless of the clock, the block SHALL force state=REQ, pc=RESET_PC, flush=0, instr_valid=0, instr=0, instr_pc=0, fault=0 and fault_pc=0.
REQ-018 While reset is asserted, imem_req_valid SHALL be 0, and the first request SHALL be issued in the first cycle after deassertion.
REQ-019 A reset asserted while in WAIT SHALL cause the late response to be ignored until the block has issued a new request.

Configuration
REQ-020 With the macro FETCH_WRAP_TRAP_EN defined, an increment from pc=32'hFFFF_FFFC SHALL enter FAULT with fault_pc=32'hFFFF_FFFC, and the instruction fetched at that address SHALL NOT be presented.
REQ-021 With FETCH_WRAP_TRAP_EN undefined, the PC SHALL wrap to 32'h0000_0000 and fetching SHALL continue normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release, ready=1, 1-cycle response: imem_addr shall be 0x0, 0x4, 0x8, with instr_valid every 3rd cycle and instr_pc matching.
- stall held 5 cycles in OUT at pc 0x8: instr and instr_pc shall be stable and imem_req_valid=0; after stall drops, the next address shall be 0xC.
- branch_taken to 0x100 in WAIT, with the response arriving 2 cycles later: the response shall be dropped, with no instr_valid; the next imem_addr shall be 0x100.
- branch_taken to 0x102: fault=1 and fault_pc=0x102 shall hold for 10 cycles, and no requests shall be issued.
- Branch to 0xFFFFFFFC, then a fetch: with FETCH_WRAP_TRAP_EN, fault=1 and fault_pc=0xFFFFFFFC; without it, the next imem_addr shall be 0x0.
- Reset asserted mid-WAIT, with the response arriving during reset: no instr_valid, and the first post-reset address shall be RESET_PC.
